// File: rtl/myo_servo_pkg.sv
// Shared constants, widths and FSM state type for the servo PWM generator.
package myo_servo_pkg;

   localparam int unsigned TICK_DIV  = 50;
   localparam int unsigned PERIOD_US = 20000;
   localparam int unsigned MIN_US    = 500;
   localparam int unsigned MAX_US    = 2500;

   localparam int unsigned US_W  = 15;
   localparam int unsigned CMD_W = 14;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;

endpackage

// File: rtl/myo_us_tick.sv
// Microsecond prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
module myo_us_tick
   import myo_servo_pkg::*;
#(
   parameter int unsigned TICK_DIV = myo_servo_pkg::TICK_DIV
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

   logic [DivW-1:0] div_cnt_q, div_cnt_d;

   assign tick_o = en_i && (div_cnt_q == DivLast);

   always_comb begin
      div_cnt_d = div_cnt_q;
      if (clr_i) begin
         div_cnt_d = '0;
      end else if (en_i) begin
         div_cnt_d = tick_o ? '0 : div_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/myo_servo_pwm.sv
// Hobby-servo frame generator; pulse width is latched only at frame start.
// Define SERVO_PWM_CLAMP_EN to clamp commands into [MIN_US, MAX_US].
module myo_servo_pwm
   import myo_servo_pkg::*;
#(
   parameter int unsigned TICK_DIV  = myo_servo_pkg::TICK_DIV,
   parameter int unsigned PERIOD_US = myo_servo_pkg::PERIOD_US,
   parameter int unsigned MIN_US    = myo_servo_pkg::MIN_US,
   parameter int unsigned MAX_US    = myo_servo_pkg::MAX_US
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [CMD_W-1:0] pulse_width,
   output logic             servo_out,
   output logic             frame_start,
   output logic             active
);

   localparam logic [US_W-1:0] UsLast = US_W'(PERIOD_US - 1);

   if (MIN_US > MAX_US || MAX_US >= PERIOD_US || PERIOD_US < 2 || PERIOD_US > 32767 ||
       TICK_DIV < 1) begin : gen_cfg_err
      $error("myo_servo_pwm: illegal parameter set");
   end

   function automatic logic [CMD_W-1:0] eff(input logic [CMD_W-1:0] w);
`ifdef SERVO_PWM_CLAMP_EN
      if (w < CMD_W'(MIN_US)) begin
         return CMD_W'(MIN_US);
      end else if (w > CMD_W'(MAX_US)) begin
         return CMD_W'(MAX_US);
      end else begin
         return w;
      end
`else
      return w;
`endif
   endfunction

   state_e           state_q, state_d;
   logic [CMD_W-1:0] shadow_q, shadow_d;
   logic [US_W-1:0]  us_cnt_q, us_cnt_d;
   logic             servo_q, servo_d;
   logic             fs_q, fs_d;
   logic             active_q, active_d;

   logic             tick;
   logic             start;
   logic [CMD_W-1:0] eff_cmd;
   logic [US_W-1:0]  us_next;

   assign eff_cmd = eff(pulse_width);

   myo_us_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_us_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (state_q == StRun),
      .clr_i   (start),
      .tick_o  (tick)
   );

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      us_cnt_d = us_cnt_q;
      servo_d  = 1'b0;
      fs_d     = 1'b0;
      active_d = active_q;
      start    = 1'b0;
      us_next  = us_cnt_q + US_W'(tick);

      case (state_q)
         StIdle: begin
            if (enable) start = 1'b1;
         end
         StRun: begin
            if (tick && (us_cnt_q == UsLast)) begin
               if (enable) begin
                  start = 1'b1;
               end else begin
                  state_d  = StIdle;
                  active_d = 1'b0;
                  us_cnt_d = '0;
               end
            end else begin
               us_cnt_d = us_next;
               // Output reflects the us index of the cycle that follows this edge.
               servo_d  = us_next < {1'b0, shadow_q};
            end
         end
         default: state_d = StIdle;
      endcase

      if (start) begin
         state_d  = StRun;
         shadow_d = eff_cmd;
         us_cnt_d = '0;
         fs_d     = 1'b1;
         active_d = 1'b1;
         servo_d  = (eff_cmd != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         shadow_q <= '0;
         us_cnt_q <= '0;
         servo_q  <= 1'b0;
         fs_q     <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         us_cnt_q <= us_cnt_d;
         servo_q  <= servo_d;
         fs_q     <= fs_d;
         active_q <= active_d;
      end
   end

   assign servo_out   = servo_q;
   assign frame_start = fs_q;
   assign active      = active_q;

endmodule

// File: tb/tb_myo_servo_pwm.sv
// Directed bench for myo_servo_pwm with TICK_DIV=4, PERIOD_US=100, clamp bounds 10..60.
module tb_myo_servo_pwm;

   localparam int FrameClks = 400;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [13:0] pulse_width;
   logic        servo_out;
   logic        frame_start;
   logic        active;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [13:0] pw;
      int          exp_nc;
      int          exp_cl;
   } vec_t;

   vec_t vecs[11];

   always #5 clk = ~clk;

   myo_servo_pwm #(
      .TICK_DIV  (4),
      .PERIOD_US (100),
      .MIN_US    (10),
      .MAX_US    (60)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .pulse_width (pulse_width),
      .servo_out   (servo_out),
      .frame_start (frame_start),
      .active      (active)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called on the frame_start cycle; runs until the next frame_start or a cycle bound.
   task automatic measure_frame(input int change_at, input logic [13:0] new_pw,
                                input int exp_high, output int len, output int high,
                                output int bad);
      len  = 0;
      high = 0;
      bad  = 0;
      do begin
         if (servo_out) high++;
         if (servo_out !== (len < exp_high)) bad++;
         if (active !== 1'b1) bad++;
         if (len == change_at) pulse_width = new_pw;
         len++;
         step();
      end while (frame_start !== 1'b1 && len < 1000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len, high, bad, exp;
      logic [13:0] nxt;

      vecs[0]  = '{14'd25,    100, 100};
      vecs[1]  = '{14'd50,    200, 200};
      vecs[2]  = '{14'd0,     0,   40};
      vecs[3]  = '{14'd120,   400, 240};
      vecs[4]  = '{14'd100,   400, 240};
      vecs[5]  = '{14'd99,    396, 240};
      vecs[6]  = '{14'd1,     4,   40};
      vecs[7]  = '{14'd3,     12,  40};
      vecs[8]  = '{14'd16383, 400, 240};
      vecs[9]  = '{14'd60,    240, 240};
      vecs[10] = '{14'd61,    244, 240};

      // Reset wins even with enable asserted.
      reset_n     = 1'b0;
      enable      = 1'b1;
      pulse_width = 14'd25;
      repeat (3) step();
      check("reset servo_out", int'(servo_out), 0);
      check("reset frame_start", int'(frame_start), 0);
      check("reset active", int'(active), 0);

      enable  = 1'b0;
      reset_n = 1'b1;
      repeat (3) step();
      check("idle frame_start", int'(frame_start), 0);
      check("idle active", int'(active), 0);

      enable      = 1'b1;
      pulse_width = vecs[0].pw;
      step();
      check("start frame_start", int'(frame_start), 1);
      check("start servo_out", int'(servo_out), 1);
      check("start active", int'(active), 1);

      // Each frame: next command written mid-frame at clock 150 must not disturb it.
      for (int i = 0; i < 11; i++) begin
`ifdef SERVO_PWM_CLAMP_EN
         exp = vecs[i].exp_cl;
`else
         exp = vecs[i].exp_nc;
`endif
         nxt = (i < 10) ? vecs[i+1].pw : 14'd25;
         measure_frame(150, nxt, exp, len, high, bad);
         check($sformatf("vec%0d frame length", i), len, FrameClks);
         check($sformatf("vec%0d high clocks", i), high, exp);
         check($sformatf("vec%0d shape errors", i), bad, 0);
      end

      // Enable drop at clock 50: frame completes, then idle.
      bad  = 0;
      high = 0;
      for (int k = 0; k < FrameClks; k++) begin
         if (servo_out) high++;
         if (servo_out !== (k < 100)) bad++;
         if (active !== 1'b1) bad++;
         if (k > 0 && frame_start !== 1'b0) bad++;
         if (k == 50) enable = 1'b0;
         step();
      end
      check("drop high clocks", high, 100);
      check("drop shape errors", bad, 0);
      check("drop end active", int'(active), 0);
      check("drop end servo_out", int'(servo_out), 0);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (frame_start !== 1'b0 || active !== 1'b0 || servo_out !== 1'b0) bad++;
         step();
      end
      check("idle after drop", bad, 0);
      enable = 1'b1;
      step();
      check("restart frame_start", int'(frame_start), 1);
      check("restart servo_out", int'(servo_out), 1);

      // Reset for one edge at clock 30 of a frame, enable held high.
      repeat (30) step();
      check("pre-reset servo_out", int'(servo_out), 1);
      reset_n = 1'b0;
      step();
      check("mid reset servo_out", int'(servo_out), 0);
      check("mid reset active", int'(active), 0);
      check("mid reset frame_start", int'(frame_start), 0);
      reset_n = 1'b1;
      step();
      check("post reset frame_start", int'(frame_start), 1);
      check("post reset active", int'(active), 1);
      measure_frame(-1, 14'd25, 100, len, high, bad);
      check("post reset frame length", len, FrameClks);
      check("post reset high clocks", high, 100);
      check("post reset shape errors", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/myo_servo_pwm.md
# myo_servo_pwm

Servo pulse generator downstream of the 14-bit Avalon PIO output word that carries the commanded servo pulse width. Converts that word (microseconds) into a standard hobby-servo frame: one high pulse per fixed period. Latches the word only at frame boundaries, so software writes mid-frame never produce a truncated or stretched pulse. Drives one servo of the hand actuator.

## Interface
- TICK_DIV, 50, clock cycles per 1 µs tick (50 MHz clk)
- PERIOD_US, 20000, frame length in µs; legal range 2..32767
- MIN_US, 500, lower clamp bound in µs
- MAX_US, 2500, upper clamp bound in µs; MIN_US ≤ MAX_US < PERIOD_US
- clk  in  1  system clock; the only clock
- reset_n  in  1  reset; synchronous, active-low
- enable  in  1  run request; level-sensitive
- pulse_width  in  14  commanded high time in µs (PIO out_port)
- servo_out  out  1  registered PWM output to servo
- frame_start  out  1  one-cycle strobe on the first cycle of each frame
- active  out  1  high while a frame is in progress

## Operation
- States: IDLE, RUN.
- Reset, synchronous on any edge with reset_n=0, takes effect even mid-frame: state=IDLE, servo_out=0, frame_start=0, active=0, shadow=0, div_cnt=0, us_cnt=0.
- IDLE → RUN on the first edge with enable=1. That edge starts a frame:
  - shadow ← eff(pulse_width)
  - div_cnt ← 0, us_cnt ← 0
  - frame_start ← 1, active ← 1
  - servo_out ← (eff(pulse_width) ≠ 0)
- In RUN, div_cnt counts 0..TICK_DIV-1. When it wraps, us_cnt increments.
- Each cycle, servo_out ← (us index of the next cycle < shadow). The high time is therefore exactly shadow×TICK_DIV clocks, beginning in the frame_start cycle.
- End of frame is the edge where div_cnt=TICK_DIV-1 and us_cnt=PERIOD_US-1:
  - enable=1: the next frame starts on that edge (same actions as above; back-to-back, no gap).
  - enable=0: go to IDLE; servo_out=0, active=0.
- Dropping enable mid-frame never truncates a frame; the frame completes first.
- pulse_width is sampled only on frame-start edges. Changes at any other time are ignored until the next frame.
- eff(): see Configuration.
- Arithmetic:
  - us_cnt is 15 bits unsigned and is compared against a 14-bit shadow zero-extended to 15 bits.
  - If shadow ≥ PERIOD_US, servo_out stays high for the whole frame.
  - If shadow = 0, servo_out stays low for the whole frame.

## Timing
- Latency from pulse_width change to effect: up to one frame plus one cycle (next frame-start edge).
- Latency from enable rise (in IDLE) to frame_start/servo_out high: 1 clock.
- Frame length: exactly PERIOD_US×TICK_DIV clocks. frame_start strobes are spaced by this amount while enable stays high.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Simultaneous reset_n=0 and end-of-frame: reset wins.

## Configuration
- SERVO_PWM_CLAMP_EN defined: eff(w) = MIN_US if w < MIN_US, MAX_US if w > MAX_US, otherwise w. Zero and out-of-range commands can never reach the servo.
- Not defined: eff(w) = w, with the 0 and ≥PERIOD_US rules above. MIN_US and MAX_US are unused.

## Structure
- Package myo_servo_pkg holds:
  - default constants: TICK_DIV, PERIOD_US, MIN_US, MAX_US
  - the state enum (IDLE, RUN)
  - US_W=15 and CMD_W=14 width constants
- Sub-module myo_us_tick: the TICK_DIV prescaler. Outputs a tick on div_cnt wrap and supports a synchronous clear input driven at frame start.
- The top level holds the FSM, shadow register, us_cnt, the clamp function and the output registers.

## Test plan
Bench uses TICK_DIV=4 and PERIOD_US=100; clamp runs use MIN_US=10, MAX_US=60.

1. Basic frame: reset, enable=1, pulse_width=25 → frame_start 1 cycle after enable; servo_out high exactly 100 clocks then low for 300; next frame_start 400 clocks after the first.
2. Mid-frame write: pulse_width 25→50 at clock 150 of a frame → current frame keeps its 100-clock pulse; next frame pulse is 200 clocks.
3. Clamp, macro defined: pulse_width=3 → 40-clock pulse; pulse_width=16383 → 240-clock pulse.
4. Clamp, macro undefined: pulse_width=0 → servo_out never high, frame_start still every 400 clocks; pulse_width=120 → servo_out high for all 400 clocks.
5. Enable drop: enable→0 at clock 50 of a frame → pulse completes, frame runs to 400 clocks, then IDLE (active=0, no further frame_start); enable→1 → frame_start next cycle.
6. Reset mid-pulse: reset_n=0 for one edge at clock 30 → next cycle servo_out=0, active=0; with enable still 1, a new frame starts on the first edge after release.
